// File: rtl/attn_pkg.sv
// Shared definitions for the attention datapath: default element geometry,
// controller state encoding and index-width helper.
package attn_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_DATA_LENGTH = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  // A single-chunk row still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/min_reduce_ctrl_min.sv
// Combinational unsigned minimum across DATA_LENGTH lanes; on equal values
// the lowest lane wins, which does not change the result value.
module Min #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_LENGTH = 8
) (
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] data,
  output logic [DATA_WIDTH-1:0]             min_val
);

  always_comb begin
    min_val = data[DATA_WIDTH-1:0];
    for (int k = 1; k < DATA_LENGTH; k++) begin
      if (data[DATA_WIDTH*k +: DATA_WIDTH] < min_val)
        min_val = data[DATA_WIDTH*k +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/min_reduce_ctrl.sv
// Streams a row of NUM_CHUNKS chunks through one shared Min and keeps a
// running minimum plus the index of the first chunk that produced it.
//
// state    | meaning
// ST_ACCUM | accepting chunks of the current row
// ST_DONE  | result presented, waiting for out_ready
module min_reduce_ctrl
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
  parameter int NUM_CHUNKS  = 4,
  parameter int IDX_WIDTH   = idx_width(NUM_CHUNKS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_min,
  output logic [IDX_WIDTH-1:0]              out_chunk_idx,
  output logic                              busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_CNT = IDX_WIDTH'(NUM_CHUNKS - 1);

  state_e                 state, state_nxt;
  logic [IDX_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]  run_min;
  logic [IDX_WIDTH-1:0]   run_idx;
  logic [DATA_WIDTH-1:0]  cmin;
  logic                   accept;

  Min #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_LENGTH (DATA_LENGTH)
  ) u_min (
    .data    (in_data),
    .min_val (cmin)
  );

  assign accept = in_valid && (state == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (accept && (cnt == LAST_CNT)) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)                   state_nxt = ST_ACCUM;
      default:                                   state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready      = (state == ST_ACCUM);
    out_valid     = (state == ST_DONE);
    out_min       = run_min;
    out_chunk_idx = run_idx;
    busy          = (state == ST_DONE) || (cnt != '0);
  end

  // Strict less-than keeps the earliest chunk when minima tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      run_min <= '0;
      run_idx <= '0;
    end else if (accept) begin
      if (cnt == '0) begin
        run_min <= cmin;
        run_idx <= '0;
      end else if (cmin < run_min) begin
        run_min <= cmin;
        run_idx <= cnt;
      end
      if (cnt == LAST_CNT) cnt <= '0;
      else                 cnt <= cnt + IDX_WIDTH'(1);
    end
  end

endmodule
